// File: rtl/register_file_param.sv
// Parameterised register file with two combinational read ports, one write port,
// optional hardwired-zero r0, optional write-to-read bypass and a busy scoreboard.
module register_file_param #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [WIDTH-1:0]  WD3,
  input  logic [ADDR_W-1:0] AS,
  input  logic              SE,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic [ADDR_W:0]   NBUSY
);

  localparam int unsigned NRegs = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs_q [NRegs];
  logic [NRegs-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   nbusy_q, nbusy_d;
  logic              wr_en;
  logic              set_en;
  logic              byp1, byp2;
  logic              zero1, zero2;

  // Writes and issues targeting a hardwired-zero r0 are dropped entirely.
  assign wr_en  = WE3 && !(ZERO_R0 && (A3 == '0));
  assign set_en = SE  && !(ZERO_R0 && (AS == '0));

  assign byp1  = BYPASS && wr_en && (A1 == A3);
  assign byp2  = BYPASS && wr_en && (A2 == A3);
  assign zero1 = ZERO_R0 && (A1 == '0);
  assign zero2 = ZERO_R0 && (A2 == '0);

  // Read data is forced to zero while reset is held, which also masks bypass.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (RESETN) begin
      if (byp1)        RD1 = WD3;
      else if (!zero1) RD1 = regs_q[A1];
      if (byp2)        RD2 = WD3;
      else if (!zero2) RD2 = regs_q[A2];
    end
  end

  // Set is applied after clear so a new issue beats a completing write.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[A3] = 1'b0;
    if (set_en) busy_d[AS] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_comb begin
    nbusy_d = '0;
    for (int i = 0; i < NRegs; i++) begin
      nbusy_d = nbusy_d + (ADDR_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NRegs; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      if (wr_en) regs_q[A3] <= WD3;
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  assign BUSY1 = busy_q[A1];
  assign BUSY2 = busy_q[A2];
  assign NBUSY = nbusy_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: one bypassing instance and one
// non-bypassing instance share the same stimulus.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  a1, a2, a3, as_;
  logic        we3, se;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy1, busy2, nb_busy1, nb_busy2;
  logic [5:0]  nbusy, nb_nbusy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  register_file_param dut (
    .CLK(clk), .RESETN(resetn), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
    .AS(as_), .SE(se), .RD1(rd1), .RD2(rd2), .BUSY1(busy1), .BUSY2(busy2), .NBUSY(nbusy)
  );

  register_file_param #(.BYPASS(1'b0)) dut_nb (
    .CLK(clk), .RESETN(resetn), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
    .AS(as_), .SE(se), .RD1(nb_rd1), .RD2(nb_rd2), .BUSY1(nb_busy1), .BUSY2(nb_busy2),
    .NBUSY(nb_nbusy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; se = 1'b0; a3 = '0; as_ = '0; wd3 = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle(); a1 = 5'd0; a2 = 5'd31;
    tick(); tick();
    total++; if (rd1 !== 32'h0) $display("FAIL reset_rd1 got %h want %h", rd1, 32'h0);
    else passed++;
    total++; if (rd2 !== 32'h0) $display("FAIL reset_rd2 got %h want %h", rd2, 32'h0);
    else passed++;
    total++; if (nbusy !== 6'd0) $display("FAIL reset_nbusy got %0d want 0", nbusy);
    else passed++;
    total++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b want 0", busy2);
    else passed++;
    @(negedge clk); resetn = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    tick();
    idle(); a1 = 5'd5; a2 = 5'd5; #1;
    total++; if (rd1 !== 32'hDEADBEEF) $display("FAIL wr_rd1 got %h want deadbeef", rd1);
    else passed++;
    total++; if (rd2 !== 32'hDEADBEEF) $display("FAIL wr_rd2 got %h want deadbeef", rd2);
    else passed++;
    total++; if (nb_rd1 !== 32'hDEADBEEF) $display("FAIL wr_nb_rd1 got %h want deadbeef", nb_rd1);
    else passed++;
  endtask

  task automatic test_zero_reg();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; se = 1'b1; as_ = 5'd0; a1 = 5'd0; #1;
    total++; if (rd1 !== 32'h0) $display("FAIL r0_nobypass got %h want 0", rd1);
    else passed++;
    tick();
    idle(); #1;
    total++; if (rd1 !== 32'h0) $display("FAIL r0_read got %h want 0", rd1);
    else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL r0_busy got %b want 0", busy1);
    else passed++;
    total++; if (nbusy !== 6'd0) $display("FAIL r0_nbusy got %0d want 0", nbusy);
    else passed++;
  endtask

  task automatic test_bypass();
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h11;
    tick();
    wd3 = 32'h22; a1 = 5'd7; a2 = 5'd7; #1;
    total++; if (rd1 !== 32'h22) $display("FAIL byp_rd1 got %h want 22", rd1);
    else passed++;
    total++; if (rd2 !== 32'h22) $display("FAIL byp_rd2 got %h want 22", rd2);
    else passed++;
    total++; if (nb_rd1 !== 32'h11) $display("FAIL nobyp_rd1 got %h want 11", nb_rd1);
    else passed++;
    tick();
    idle(); #1;
    total++; if (nb_rd1 !== 32'h22) $display("FAIL nobyp_after got %h want 22", nb_rd1);
    else passed++;
    total++; if (rd1 !== 32'h22) $display("FAIL byp_after got %h want 22", rd1);
    else passed++;
  endtask

  task automatic test_scoreboard_collision();
    se = 1'b1; as_ = 5'd3; a1 = 5'd3;
    tick();
    idle(); #1;
    total++; if (busy1 !== 1'b1) $display("FAIL col_set_busy got %b want 1", busy1);
    else passed++;
    total++; if (nbusy !== 6'd1) $display("FAIL col_set_nbusy got %0d want 1", nbusy);
    else passed++;
    se = 1'b1; as_ = 5'd3; we3 = 1'b1; a3 = 5'd3; wd3 = 32'h33; #1;
    // Same-cycle completion must not clear the visible busy flag.
    total++; if (busy1 !== 1'b1) $display("FAIL col_pre_edge_busy got %b want 1", busy1);
    else passed++;
    tick();
    idle(); #1;
    total++; if (busy1 !== 1'b1) $display("FAIL col_both_busy got %b want 1", busy1);
    else passed++;
    total++; if (nbusy !== 6'd1) $display("FAIL col_both_nbusy got %0d want 1", nbusy);
    else passed++;
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h34;
    tick();
    idle(); #1;
    total++; if (busy1 !== 1'b0) $display("FAIL col_clear_busy got %b want 0", busy1);
    else passed++;
    total++; if (nbusy !== 6'd0) $display("FAIL col_clear_nbusy got %0d want 0", nbusy);
    else passed++;
  endtask

  task automatic test_parallel();
    se = 1'b1; as_ = 5'd2;
    tick();
    se = 1'b1; as_ = 5'd4; we3 = 1'b1; a3 = 5'd2; wd3 = 32'h44;
    tick();
    idle(); a1 = 5'd4; a2 = 5'd2; #1;
    total++; if (busy1 !== 1'b1) $display("FAIL par_busy4 got %b want 1", busy1);
    else passed++;
    total++; if (busy2 !== 1'b0) $display("FAIL par_busy2 got %b want 0", busy2);
    else passed++;
    total++; if (nbusy !== 6'd1) $display("FAIL par_nbusy got %0d want 1", nbusy);
    else passed++;
    total++; if (rd2 !== 32'h44) $display("FAIL par_rd2 got %h want 44", rd2);
    else passed++;
  endtask

  task automatic test_back_to_back();
    // Re-issue to busy r4, then write to idle r6.
    se = 1'b1; as_ = 5'd4;
    tick();
    idle(); we3 = 1'b1; a3 = 5'd6; wd3 = 32'h66;
    tick();
    idle(); a1 = 5'd4; a2 = 5'd6; #1;
    total++; if (nbusy !== 6'd1) $display("FAIL b2b_nbusy got %0d want 1", nbusy);
    else passed++;
    total++; if (busy2 !== 1'b0) $display("FAIL b2b_busy6 got %b want 0", busy2);
    else passed++;
    total++; if (rd2 !== 32'h66) $display("FAIL b2b_rd6 got %h want 66", rd2);
    else passed++;
  endtask

  task automatic test_async_reset();
    // r4 busy already; add 1, 5, 6, 8 for five.
    se = 1'b1; as_ = 5'd1; tick();
    as_ = 5'd5; tick();
    as_ = 5'd6; tick();
    as_ = 5'd8; tick();
    idle(); a1 = 5'd5; a2 = 5'd1; #1;
    total++; if (nbusy !== 6'd5) $display("FAIL ar_pre_nbusy got %0d want 5", nbusy);
    else passed++;
    #2;
    resetn = 1'b0; we3 = 1'b1; a3 = 5'd1; wd3 = 32'h9; #1;
    total++; if (rd1 !== 32'h0) $display("FAIL ar_rd1 got %h want 0", rd1);
    else passed++;
    total++; if (nbusy !== 6'd0) $display("FAIL ar_nbusy got %0d want 0", nbusy);
    else passed++;
    total++; if (rd2 !== 32'h0) $display("FAIL ar_bypass got %h want 0", rd2);
    else passed++;
    tick();
    @(negedge clk); resetn = 1'b1; #1;
    total++; if (rd1 !== 32'h0) $display("FAIL ar_reg5_cleared got %h want 0", rd1);
    else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL ar_busy5 got %b want 0", busy1);
    else passed++;
    tick();
    idle(); a1 = 5'd1; #1;
    total++; if (rd1 !== 32'h9) $display("FAIL ar_first_write got %h want 9", rd1);
    else passed++;
    total++; if (nb_rd1 !== 32'h9) $display("FAIL ar_nb_first_write got %h want 9", nb_rd1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard_collision();
    test_parallel();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, range 8..64.
REQ-002 Parameter ADDR_W, default 5: address width; register count NREGS = 2^ADDR_W.
REQ-003 Parameter ZERO_R0, default 1: 1 makes register 0 read as zero, ignore writes and never report busy.
REQ-004 Parameter BYPASS, default 1: 1 forwards a same-cycle write to the read ports.
REQ-005 CLK  input  1: sole clock; all state updates on its rising edge.
REQ-006 RESETN  input  1: asynchronous, active-low reset.
REQ-007 A1  input  ADDR_W: read port 1 address.
REQ-008 A2  input  ADDR_W: read port 2 address.
REQ-009 A3  input  ADDR_W: write address.
REQ-010 WE3  input  1: write enable.
REQ-011 WD3  input  WIDTH: write data.
REQ-012 AS  input  ADDR_W: scoreboard set address (destination of an issued instruction).
REQ-013 SE  input  1: scoreboard set enable.
REQ-014 RD1  output  WIDTH: read data, port 1.
REQ-015 RD2  output  WIDTH: read data, port 2.
REQ-016 BUSY1  output  1: register at A1 has a pending write.
REQ-017 BUSY2  output  1: register at A2 has a pending write.
REQ-018 NBUSY  output  ADDR_W+1: count of registers currently busy.

Function
REQ-019 Storage: NREGS words of WIDTH bits; read ports combinational, zero-latency from A1/A2.
REQ-020 Write: when WE3=1 at a rising CLK edge, reg[A3] <= WD3; when WE3=0, no storage change.
REQ-021 Write to register 0 with ZERO_R0=1: discarded; RD1/RD2 for address 0 always 0.
REQ-022 Bypass (BYPASS=1): if WE3=1 and A1==A3 (A3 not 0 under ZERO_R0), RD1=WD3 in the same cycle; same rule for RD2 with A2.
REQ-023 BYPASS=0: RD1/RD2 show the stored value; a write is visible the cycle after the edge.
REQ-024 Scoreboard: one busy bit per register, updated at the rising edge.
REQ-025 SE=1 sets busy[AS]; WE3=1 clears busy[A3].
REQ-026 SE=1 and WE3=1 with AS==A3: busy[AS] ends set (the new issue wins over the completing write).
REQ-027 SE=1 and WE3=1 with AS!=A3: both updates take effect in the same edge.
REQ-028 SE to an already-busy register: it stays busy; no count change.
REQ-029 WE3 to a non-busy register: the data is written; busy stays 0.
REQ-030 ZERO_R0=1: SE to register 0 is ignored and busy[0] is constant 0.
REQ-031 BUSY1 = busy[A1], BUSY2 = busy[A2], both combinational.
REQ-032 BUSY1/BUSY2 reflect registered state only; same-cycle WE3 does not clear them, regardless of BYPASS.
REQ-033 NBUSY equals the population count of the busy bits.
REQ-034 NBUSY is registered and updated at the same edge as the busy bits, so it is always consistent with them.
REQ-035 NBUSY never exceeds NREGS, or NREGS-1 when ZERO_R0=1.

Reset
REQ-036 RESETN low immediately and asynchronously clears every register word to 0, every busy bit to 0 and NBUSY to 0.
REQ-037 While RESETN is low, WE3 and SE are ignored; RD1/RD2 read 0 for all addresses and bypass is suppressed.
REQ-038 Reset asserted mid-operation discards the pending scoreboard state; there is no recovery of in-flight entries.
REQ-039 Deassertion of RESETN takes effect at the first rising CLK edge after it goes high; no write or set is lost at that edge.

Verification
REQ-040 Write/read: WE3=1, A3=5, WD3=0xDEADBEEF, edge; then A1=5, A2=5 -> RD1=RD2=0xDEADBEEF.
REQ-041 Zero register: WE3=1, A3=0, WD3=0xFFFFFFFF, edge; A1=0 -> RD1=0, BUSY1=0.
REQ-042 Bypass: BYPASS=1, reg7=0x11, same cycle WE3=1, A3=7, WD3=0x22, A1=7 -> RD1=0x22 before the edge. With BYPASS=0 -> RD1=0x11, then 0x22 after the edge.
REQ-043 Scoreboard collision: SE=1, AS=3, edge -> BUSY1=1 at A1=3, NBUSY=1. Next cycle SE=1, AS=3, WE3=1, A3=3 -> busy stays 1, NBUSY=1. Next cycle WE3=1, A3=3 -> BUSY1=0, NBUSY=0.
REQ-044 Parallel update: busy{2}; SE=1, AS=4, WE3=1, A3=2, edge -> busy{4}, NBUSY=1.
REQ-045 Async reset: regs loaded and NBUSY=5; RESETN low between edges -> RD1=0 and NBUSY=0 immediately. First edge after release with WE3=1, A3=1, WD3=9 -> reg1=9.
